fused_dot_pe: RTL and testbench
===============================

FUSED_DOT_PE -- requirements
Module: fused_dot_pe

Interface
REQ-001 SHALL have parameter BW, default 8; packed operand width; power of two, 4..16.
REQ-002 SHALL have parameter ACC_W, default 32; accumulator/result width, >= 2*BW+4.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  BW  packed activations.
REQ-008 SHALL have port w  input  BW  packed weights.
REQ-009 SHALL have port mode  input  2  element precision P = BW >> mode (0: P=BW, 1: BW/2, 2: BW/4).
REQ-010 SHALL have port sgn  input  1  1 = signed two's-complement elements, 0 = unsigned.
REQ-011 SHALL have port acc_clr  input  1  beat starts a new accumulation.
REQ-012 SHALL have port acc_last  input  1  beat ends the accumulation; result emitted.
REQ-013 SHALL have port out_valid  output  1  result held on out_data.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_data  output  ACC_W  accumulated dot product.

Function
REQ-016 SHALL treat each beat as N = BW/P element pairs, element i at bits [i*P +: P] of a and w; beat sum = sum over i of a_i*w_i, sign per sgn.
REQ-017 SHALL sample mode, sgn, acc_clr and acc_last per beat.
REQ-018 SHALL treat any beat with P < 2 (including mode=3) as a zero-contribution beat whose flags still act.
REQ-019 SHALL sign-extend (sgn=1) or zero-extend (sgn=0) each beat sum to ACC_W.
REQ-020 SHALL accumulate modulo 2^ACC_W with no saturation or overflow flag.
REQ-021 SHALL pipeline in two stages: S1 registers the 2x2 partial products; S2 shift-adds them and updates the accumulator.
REQ-022 SHALL set acc = beat sum when acc_clr=1, otherwise acc = acc + beat sum.
REQ-023 SHALL, for a beat carrying both acc_clr and acc_last, output its beat sum alone.
REQ-024 SHALL, when the acc_last beat is accepted at edge t, present out_valid=1 after edge t+2.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive in_ready = !out_valid || out_ready, and stall S1/S2 on the same condition; no beat is lost or duplicated.
REQ-027 SHALL clear out_valid on the handshake edge unless a new result lands in the same cycle, giving back-to-back results at one per cycle.
REQ-028 SHALL leave the accumulator intact when out_valid drops.
REQ-029 SHALL treat a beat after acc_last without acc_clr as continuing from the last result.

Reset
REQ-030 SHALL on nrst=0 immediately clear S1/S2 valid bits, the accumulator, out_valid and out_data to 0, and drive in_ready=1.
REQ-031 SHALL discard in-flight beats on reset mid-operation, with no result emitted after release.

Structure
REQ-032 SHALL place the mode encodings and the N/P derivation functions in shared package fused_pe_pkg.
REQ-033 SHALL build products from an array of (BW/2)^2 instances of sub-module bitbrick (2x2-bit, signed/unsigned, 4-bit product).
REQ-034 SHALL contain no state outside the S1 product registers, the accumulator, and the valid/output registers.

Verification
REQ-035 SHALL verify signed 8-bit: BW=8, mode=0, sgn=1, a=0xFD, w=0x05, clr+last -> out_data=0xFFFFFFF1 two cycles later.
REQ-036 SHALL verify unsigned 4-bit: mode=1, sgn=0, a=0xF3, w=0x21, clr+last -> out_data=33.
REQ-037 SHALL verify signed 2-bit: mode=2, sgn=1, a=0xFF, w=0x55 -> -4 (0xFFFFFFFC).
REQ-038 SHALL verify accumulation: three mode=0 unsigned beats 10*10, 20*3, 1*1 (clr on first, last on third) -> 161, out_valid for exactly one cycle with out_ready=1.
REQ-039 SHALL verify backpressure: out_ready=0 for 5 cycles with beats offered -> in_ready=0, out_data held, results after release in order and intact.
REQ-040 SHALL verify reset: nrst low one cycle after a clr beat -> out_valid=0, accumulator 0, and no stale result after release.

Source files
------------

// File: rtl/fused_pe_pkg.sv
// Shared definitions for the fused dot-product PE: precision mode encodings
// and the helpers that derive element width, element count and the chunk
// grouping used to fuse 2-bit bitbricks into wider multipliers.
package fused_pe_pkg;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2,
    MODE_RSVD    = 2'd3
  } pe_mode_e;

  localparam int BB_W      = 2;
  localparam int BB_PROD_W = 4;

  // Element precision P = BW >> mode.
  function automatic int prec_bits(input int bw, input logic [1:0] mode);
    return bw >> mode;
  endfunction

  // A beat only contributes when elements are at least one bitbrick wide.
  function automatic logic prec_ok(input int bw, input logic [1:0] mode);
    return prec_bits(bw, mode) >= BB_W;
  endfunction

  // Number of element pairs N = BW / P (0 for a zero-contribution beat).
  function automatic int num_elems(input int bw, input logic [1:0] mode);
    int p;
    p = prec_bits(bw, mode);
    return (p < BB_W) ? 0 : bw / p;
  endfunction

  // Chunks per element minus one; chunk j belongs to element j & ~mask and
  // sits at chunk offset j & mask inside it.
  function automatic int chunk_mask(input int bw, input logic [1:0] mode);
    int p;
    p = prec_bits(bw, mode);
    return (p < BB_W) ? 0 : (p / BB_W) - 1;
  endfunction

endpackage

// File: rtl/fused_dot_pe_bitbrick.sv
// 2x2-bit multiplier brick. Each operand is independently signed or
// unsigned; the 4-bit product is exact and is to be read as signed whenever
// either operand is signed, unsigned otherwise.
module bitbrick
  import fused_pe_pkg::*;
(
  input  logic [BB_W-1:0]      i_a,
  input  logic [BB_W-1:0]      i_w,
  input  logic                 i_a_sgn,
  input  logic                 i_w_sgn,
  output logic [BB_PROD_W-1:0] o_p
);

  logic signed [BB_W:0]        w_a_ext;
  logic signed [BB_W:0]        w_w_ext;
  logic signed [BB_PROD_W-1:0] w_prod;

  assign w_a_ext = {i_a_sgn & i_a[BB_W-1], i_a};
  assign w_w_ext = {i_w_sgn & i_w[BB_W-1], i_w};
  assign w_prod  = w_a_ext * w_w_ext;
  assign o_p     = w_prod;

endmodule

// File: rtl/fused_dot_pe.sv
// Precision-scalable dot-product PE. A beat carries BW-bit packed a/w words
// split into BW/P element pairs; the beat sum is accumulated and emitted on
// acc_last. Pipeline: S1 bitbrick products, S2 shift-add + accumulate,
// then the output register (result visible two edges after acceptance).
// The whole pipe advances only when the output register can take data.
module fused_dot_pe
  import fused_pe_pkg::*;
#(
  parameter int BW    = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    a,
  input  logic [BW-1:0]    w,
  input  logic [1:0]       mode,
  input  logic             sgn,
  input  logic             acc_clr,
  input  logic             acc_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  localparam int NB  = BW / BB_W;
  localparam int NPP = NB * NB;

  function automatic logic [ACC_W-1:0] ext_pp(input logic [BB_PROD_W-1:0] p,
                                              input logic s);
    return s ? {{(ACC_W-BB_PROD_W){p[BB_PROD_W-1]}}, p}
             : {{(ACC_W-BB_PROD_W){1'b0}}, p};
  endfunction

  logic                          w_adv;
  logic                          w_in_ok;
  int                            w_in_mask;
  logic [NB-1:0]                 w_top_in;
  logic [NPP-1:0][BB_PROD_W-1:0] w_pp;
  int                            w_s1_mask;
  logic [ACC_W-1:0]              w_beat_sum;
  logic [ACC_W-1:0]              w_acc_next;

  logic                          r_s1_valid;
  logic                          r_s1_clr;
  logic                          r_s1_last;
  logic                          r_s1_sgn;
  pe_mode_e                      r_s1_mode;
  logic [NPP-1:0][BB_PROD_W-1:0] r_pp;
  logic                          r_s2_emit;
  logic [ACC_W-1:0]              r_acc;
  logic                          r_out_valid;
  logic [ACC_W-1:0]              r_out_data;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_in_ok   = prec_ok(BW, mode);
  assign w_in_mask = chunk_mask(BW, mode);

  // Mark the most-significant chunk of each element; only it carries the sign.
  always_comb begin
    w_top_in = '0;
    for (int j = 0; j < NB; j++) begin
      w_top_in[j] = w_in_ok && ((j & w_in_mask) == w_in_mask);
    end
  end

  for (genvar gj = 0; gj < NB; gj++) begin : g_row
    for (genvar gk = 0; gk < NB; gk++) begin : g_col
      bitbrick u_bb (
        .i_a     (a[gj*BB_W +: BB_W]),
        .i_w     (w[gk*BB_W +: BB_W]),
        .i_a_sgn (sgn & w_top_in[gj]),
        .i_w_sgn (sgn & w_top_in[gk]),
        .o_p     (w_pp[gj*NB + gk])
      );
    end
  end

  // S1: capture partial products and the beat's control flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1_valid <= 1'b0;
      r_s1_clr   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sgn   <= 1'b0;
      r_s1_mode  <= MODE_FULL;
      r_pp       <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_clr  <= acc_clr;
        r_s1_last <= acc_last;
        r_s1_sgn  <= sgn;
        r_s1_mode <= pe_mode_e'(mode);
        r_pp      <= w_pp;
      end
    end
  end

  assign w_s1_mask = chunk_mask(BW, r_s1_mode);

  // Shift-add only the chunk pairs that fall inside the same element.
  always_comb begin
    w_beat_sum = '0;
    if (prec_ok(BW, r_s1_mode)) begin
      for (int j = 0; j < NB; j++) begin
        for (int k = 0; k < NB; k++) begin
          if ((j & ~w_s1_mask) == (k & ~w_s1_mask)) begin
            w_beat_sum = w_beat_sum +
              (ext_pp(r_pp[j*NB + k],
                      r_s1_sgn && (((j & w_s1_mask) == w_s1_mask) ||
                                   ((k & w_s1_mask) == w_s1_mask)))
               << (2 * ((j & w_s1_mask) + (k & w_s1_mask))));
          end
        end
      end
    end
  end

  assign w_acc_next = r_s1_clr ? w_beat_sum : r_acc + w_beat_sum;

  // S2: update the accumulator and flag a finished accumulation for output.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s2_emit <= 1'b0;
      r_acc     <= '0;
    end else if (w_adv) begin
      r_s2_emit <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_acc <= w_acc_next;
      end
    end
  end

  // Output register: load a finished result, otherwise drop valid on handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_emit;
      if (r_s2_emit) begin
        r_out_data <= r_acc;
      end
    end
  end

endmodule

// File: tb/tb_fused_dot_pe.sv
// Scoreboard bench for fused_dot_pe: the stimulus side computes expected
// results from a plain arithmetic model and queues them; a monitor pops and
// compares on every output handshake and checks data holds under stall.
module tb_fused_dot_pe;

  localparam int BW    = 8;
  localparam int ACC_W = 32;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BW-1:0]    a = '0;
  logic [BW-1:0]    w = '0;
  logic [1:0]       mode = '0;
  logic             sgn = 1'b0;
  logic             acc_clr = 1'b0;
  logic             acc_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;

  fused_dot_pe #(.BW(BW), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .w         (w),
    .mode      (mode),
    .sgn       (sgn),
    .acc_clr   (acc_clr),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  int              last_acc_cyc = 0;
  bit              rnd_rdy = 1'b0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] m_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait expired, got timeout, expected DUT event", name);
    finish_run();
  endtask

  // Reference: sum of element products straight from the element definition.
  function automatic logic [ACC_W-1:0] model_beat(input logic [BW-1:0] va, input logic [BW-1:0] vw,
                                                  input logic [1:0] md, input logic s);
    int     p;
    longint sum, ea, ew, msk;
    p   = BW >> md;
    sum = 0;
    if (p < 2) return '0;
    msk = (longint'(1) << p) - 1;
    for (int i = 0; i < BW / p; i++) begin
      ea = (longint'(va) >> (i * p)) & msk;
      ew = (longint'(vw) >> (i * p)) & msk;
      if (s && ea >= (longint'(1) << (p - 1))) ea = ea - (longint'(1) << p);
      if (s && ew >= (longint'(1) << (p - 1))) ew = ew - (longint'(1) << p);
      sum = sum + ea * ew;
    end
    return ACC_W'(sum);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [BW-1:0] ia, input logic [BW-1:0] iw, input logic [1:0] im,
                      input logic is, input logic ic, input logic il,
                      input bit use_exp = 1'b0, input logic [ACC_W-1:0] xv = '0);
    bit               took;
    int               waitc;
    logic [ACC_W-1:0] bs;
    a = ia; w = iw; mode = im; sgn = is; acc_clr = ic; acc_last = il;
    in_valid = 1'b1;
    took  = 1'b0;
    waitc = 0;
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      tick();
      waitc++;
      if (!took && waitc > 200) timeout("in_ready_wait");
    end
    in_valid = 1'b0;
    last_acc_cyc = cyc;
    bs    = model_beat(ia, iw, im, is);
    m_acc = ic ? bs : m_acc + bs;
    if (il) exp_q.push_back(use_exp ? xv : m_acc);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    m_acc = '0;
    exp_q.delete();
  endtask

  // Monitor: compare every delivered result and check stability under stall.
  logic [ACC_W-1:0] held = '0;
  bit               stall_prev = 1'b0;
  always @(negedge clk) begin
    if (!nrst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", out_data);
        end else begin
          check("result", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      stall_prev <= out_valid && !out_ready;
      held       <= out_data;
    end
  end

  initial begin
    int vc;
    int n;
    logic [1:0] rm;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    out_ready = 1'b1;
    tick();

    // signed 8-bit, latency two edges after acceptance
    send(8'hFD, 8'h05, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check("latency", 64'(cyc - last_acc_cyc), 64'd2);
    repeat (3) tick();

    send(8'hF3, 8'h21, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd33);
    send(8'hFF, 8'h55, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    send(8'h7F, 8'h7F, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0);
    send(8'd2, 8'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd6);
    send(8'd1, 8'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd7);
    repeat (4) tick();

    // three-beat accumulation, valid for exactly one cycle
    send(8'd10, 8'd10, 2'd0, 1'b0, 1'b1, 1'b0);
    send(8'd20, 8'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    send(8'd1, 8'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd161);
    vc = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) vc++;
    end
    check("single_cycle_valid", 64'(vc), 64'd1);
    tick();

    // backpressure
    out_ready = 1'b0;
    send(8'd3, 8'd4, 2'd0, 1'b0, 1'b1, 1'b1);
    send(8'd5, 8'd5, 2'd0, 1'b0, 1'b0, 1'b1);
    send(8'hF9, 8'h13, 2'd1, 1'b1, 1'b1, 1'b1);
    a = 8'h81; w = 8'h7E; mode = 2'd0; sgn = 1'b1; acc_clr = 1'b0; acc_last = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h81, 8'h7E, 2'd0, 1'b1, 1'b0, 1'b1);
    repeat (6) tick();

    // reset one cycle after a clr beat: accumulator must restart from 0
    send(8'd9, 8'd9, 2'd0, 1'b0, 1'b1, 1'b0);
    do_reset();
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (2) tick();
    send(8'd2, 8'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4);
    repeat (4) tick();

    // reset with a result in flight: nothing may appear after release
    send(8'd6, 8'd6, 2'd0, 1'b0, 1'b1, 1'b1);
    do_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
    vc = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) vc++;
    end
    check("no_stale_result", 64'(vc), 64'd0);
    tick();

    // randomized traffic with random output backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      rm = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(8'($urandom), 8'($urandom), rm, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    send(8'($urandom), 8'($urandom), 2'd0, 1'b1, 1'b0, 1'b1);

    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    finish_run();
  end

endmodule
